// File: rtl/pipe_pkg.sv
// Shared pipeline width constants; instantiators use these to size dff_register.
package pipe_pkg;
  localparam int WORD_WIDTH      = 64;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int ALUOP_WIDTH     = 3;
  localparam int XFER_SIZE_WIDTH = 4;

  typedef logic [WORD_WIDTH-1:0]     word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
endpackage

// File: rtl/dff_register_if.sv
// Load/hold bus of a pipeline register. The clear signal exists only when
// DFF_REGISTER_SYNC_CLEAR_EN is defined.
interface dff_register_if
  import pipe_pkg::*;
#(
  parameter int N = WORD_WIDTH
);
  logic         write_en;
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;
`ifdef DFF_REGISTER_SYNC_CLEAR_EN
  logic         clear;

  modport master (output write_en, output data_in, output clear, input data_out);
  modport slave  (input write_en, input data_in, input clear, output data_out);
`else
  modport master (output write_en, output data_in, input data_out);
  modport slave  (input write_en, input data_in, output data_out);
`endif
endinterface

// File: rtl/d_ff.sv
// 1-bit rising-edge flop with asynchronous active-high reset to zero.
module d_ff (
  output logic q,
  input  logic d,
  input  logic reset,
  input  logic clk
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end
endmodule

// File: rtl/dff_register.sv
// N-bit register built from d_ff cells with a per-bit load mux.
// DFF_REGISTER_SYNC_CLEAR_EN adds a synchronous clear (reset > clear > write_en).
module dff_register
  import pipe_pkg::*;
#(
  parameter int N = WORD_WIDTH
) (
  input logic         clk,
  input logic         reset,
  dff_register_if.slave bus
);
  logic [N-1:0] d;
  logic [N-1:0] q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
`ifdef DFF_REGISTER_SYNC_CLEAR_EN
      // Flush forces a zero into the cell regardless of the load enable.
      assign d[gi] = bus.clear ? 1'b0 : (bus.write_en ? bus.data_in[gi] : q[gi]);
`else
      assign d[gi] = bus.write_en ? bus.data_in[gi] : q[gi];
`endif
      d_ff u_cell (
        .q     (q[gi]),
        .d     (d[gi]),
        .reset (reset),
        .clk   (clk)
      );
    end
  endgenerate

  assign bus.data_out = q;
endmodule

// File: tb/tb_dff_register.sv
// Scoreboard bench for dff_register at several widths plus a standalone d_ff.
module tb_dff_register;
  import pipe_pkg::*;

`ifdef DFF_REGISTER_SYNC_CLEAR_EN
  localparam bit CLEAR_ON = 1'b1;
`else
  localparam bit CLEAR_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dff_register_if #(.N(WORD_WIDTH))      bus64 ();
  dff_register_if #(.N(REG_ADDR_WIDTH))  bus5 ();
  dff_register_if #(.N(XFER_SIZE_WIDTH)) bus4 ();
  dff_register_if #(.N(ALUOP_WIDTH))     bus3 ();
  dff_register_if #(.N(1))               bus1 ();

  logic cell_d = 1'b0;
  logic cell_q;

  dff_register #(.N(WORD_WIDTH))      u_dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));
  dff_register #(.N(REG_ADDR_WIDTH))  u_dut5  (.clk(clk), .reset(reset), .bus(bus5.slave));
  dff_register #(.N(XFER_SIZE_WIDTH)) u_dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));
  dff_register #(.N(ALUOP_WIDTH))     u_dut3  (.clk(clk), .reset(reset), .bus(bus3.slave));
  dff_register #(.N(1))               u_dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));
  d_ff u_cell (.q(cell_q), .d(cell_d), .reset(reset), .clk(clk));

  typedef struct {
    logic [63:0] w64;
    logic [4:0]  w5;
    logic [3:0]  w4;
    logic [2:0]  w3;
    logic        w1;
    logic        cq;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Reference state: the last value written, expressed as a plain 64-bit word.
  logic [63:0] model = '0;
  logic        cell_model = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Narrow registers each see a different slice of the stimulus word.
  task automatic step(input logic we, input logic [63:0] din, input logic clr, input logic dbit);
    bus64.write_en = we; bus64.data_in = din;
    bus5.write_en  = we; bus5.data_in  = din[4:0];
    bus4.write_en  = we; bus4.data_in  = din[19:16];
    bus3.write_en  = we; bus3.data_in  = din[10:8];
    bus1.write_en  = we; bus1.data_in  = din[0];
`ifdef DFF_REGISTER_SYNC_CLEAR_EN
    bus64.clear = clr; bus5.clear = clr; bus4.clear = clr; bus3.clear = clr; bus1.clear = clr;
`endif
    cell_d = dbit;
    @(posedge clk);
    if (reset)                model = '0;
    else if (clr && CLEAR_ON) model = '0;
    else if (we)              model = din;
    cell_model = reset ? 1'b0 : dbit;
    sb.push_back('{model, model[4:0], model[19:16], model[10:8], model[0], cell_model});
    $display("[TB] edge @%0t reset=%0b we=%0b clr=%0b din=%h -> expect %h", $time, reset, we, clr, din, model);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w64"}, bus64.data_out, 64'd0);
    chk({tag, "_w5"},  {59'd0, bus5.data_out}, 64'd0);
    chk({tag, "_w1"},  {63'd0, bus1.data_out}, 64'd0);
    chk({tag, "_cell"}, {63'd0, cell_q}, 64'd0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("w64",  bus64.data_out, e.w64);
      chk("w5",   {59'd0, bus5.data_out}, {59'd0, e.w5});
      chk("w4",   {60'd0, bus4.data_out}, {60'd0, e.w4});
      chk("w3",   {61'd0, bus3.data_out}, {61'd0, e.w3});
      chk("w1",   {63'd0, bus1.data_out}, {63'd0, e.w1});
      chk("cell", {63'd0, cell_q}, {63'd0, e.cq});
    end
  end

  initial begin
    logic [63:0] r;
    bus64.write_en = 1'b0; bus64.data_in = '0;
    bus5.write_en  = 1'b0; bus5.data_in  = '0;
    bus4.write_en  = 1'b0; bus4.data_in  = '0;
    bus3.write_en  = 1'b0; bus3.data_in  = '0;
    bus1.write_en  = 1'b0; bus1.data_in  = '0;
`ifdef DFF_REGISTER_SYNC_CLEAR_EN
    bus64.clear = 1'b0; bus5.clear = 1'b0; bus4.clear = 1'b0; bus3.clear = 1'b0; bus1.clear = 1'b0;
`endif
    #1;
    chk_all_zero("reset_async_start");

    // Reset held across an edge, then first capture after release.
    step(1'b1, 64'd9999313, 1'b0, 1'b1);
    reset = 1'b0;
    step(1'b1, 64'd9999313, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i < 5) step(1'b1, 64'd9999313, 1'b0, i[0]);
      else       step(1'b0, {$urandom, $urandom}, 1'b0, i[0]);
    end

    // Hold against a changing input, then reload.
    step(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // Narrow widths: 5'b10111, 4'b1011, 3'b100, 1'b1 in their slices.
    step(1'b1, 64'h0000_0000_000B_0417, 1'b0, 1'b1);

    // Reset raised between edges clears everything before the next edge.
    step(1'b1, 64'd9999313, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk_all_zero("reset_async_mid");
    for (int i = 0; i < 3; i++) step(1'b1, 64'h1234_5678_9ABC_DEF1, 1'b0, 1'b1);
    reset = 1'b0;
    step(1'b0, 64'h1234_5678_9ABC_DEF1, 1'b0, 1'b1);
    step(1'b1, 64'h1234_5678_9ABC_DEF1, 1'b0, 1'b0);

    // Clear beats write_en; without the macro the same stimulus simply loads.
    step(1'b1, 64'd9999313, 1'b0, 1'b1);
    step(1'b1, 64'd5, 1'b1, 1'b0);
    step(1'b1, 64'd5, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      r = {$urandom, $urandom};
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        #1;
        chk_all_zero("reset_async_rand");
        step(1'($urandom_range(0, 1)), r, 1'b0, 1'($urandom_range(0, 1)));
        reset = 1'b0;
      end
      step(1'($urandom_range(0, 1)), r, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
